// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    // Ceiling log2, usable in parameter context.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = n - 1;
        while (v != 0) begin
            v = v >> 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Low bit index of element idx in a flattened vector of w-bit elements.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: set at issue, cleared at writeback, wiped by flush.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_pend,
    output logic [AW:0]       pend_cnt
);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic [AW:0]      cnt_nxt;

    // Clear on writeback, then set on issue so a new producer wins; flush overrides all.
    always_comb begin
        pend_nxt = pend;
        for (int unsigned w = 0; w < NWR; w++) begin
            if (wr_en[w]) pend_nxt[wr_addr[slice_lo(w, AW) +: AW]] = 1'b0;
        end
        if (iss_en) pend_nxt[iss_addr] = 1'b1;
        if (ZERO_REG != 0) pend_nxt[0] = 1'b0;
        if (flush) pend_nxt = '0;
        cnt_nxt = '0;
        for (int unsigned k = 0; k < NREGS; k++) begin
            cnt_nxt = cnt_nxt + (AW + 1)'(pend_nxt[k]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            pend_cnt <= '0;
        end else begin
            pend     <= pend_nxt;
            pend_cnt <= cnt_nxt;
        end
    end

    // A value arriving on a write port this cycle is already available.
    always_comb begin
        rd_pend = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_pend[i] = pend[rd_addr[slice_lo(i, AW) +: AW]];
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[slice_lo(w, AW) +: AW] == rd_addr[slice_lo(i, AW) +: AW]))
                    rd_pend[i] = 1'b0;
            end
            if ((ZERO_REG != 0) && (rd_addr[slice_lo(i, AW) +: AW] == '0)) rd_pend[i] = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-through bypass and an issue/writeback scoreboard.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter int unsigned NWR      = 2,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_pend,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         pend_cnt
);

    if ((NRD < 1) || (NRD > 4)) begin : g_bad_nrd
        $error("regfile_mp_sb: NRD must be 1..4");
    end
    if ((NWR < 1) || (NWR > 2)) begin : g_bad_nwr
        $error("regfile_mp_sb: NWR must be 1..2");
    end
    if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
        $error("regfile_mp_sb: NREGS must be a power of 2 and >= 2");
    end
    if ((XLEN < 1) || (ZERO_REG > 1)) begin : g_bad_misc
        $error("regfile_mp_sb: XLEN must be >= 1 and ZERO_REG 0 or 1");
    end

    logic [XLEN-1:0] regs [NREGS];

    // Ports applied in ascending order so the highest index wins on a collision.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wr_en[w] && !((ZERO_REG != 0) && (wr_addr[slice_lo(w, AW) +: AW] == '0)))
                    regs[wr_addr[slice_lo(w, AW) +: AW]] <= wr_data[slice_lo(w, XLEN) +: XLEN];
            end
        end
    end

    // Read muxes: storage, overridden by same-cycle writes, overridden by hardwired zero.
    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_data[slice_lo(i, XLEN) +: XLEN] = regs[rd_addr[slice_lo(i, AW) +: AW]];
            for (int unsigned w = 0; w < NWR; w++) begin
                if (wr_en[w] && (wr_addr[slice_lo(w, AW) +: AW] == rd_addr[slice_lo(i, AW) +: AW]))
                    rd_data[slice_lo(i, XLEN) +: XLEN] = wr_data[slice_lo(w, XLEN) +: XLEN];
            end
            if ((ZERO_REG != 0) && (rd_addr[slice_lo(i, AW) +: AW] == '0))
                rd_data[slice_lo(i, XLEN) +: XLEN] = '0;
        end
    end

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .rd_addr  (rd_addr),
        .rd_pend  (rd_pend),
        .pend_cnt (pend_cnt)
    );

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined core. Generalises the single-write, two-read file to NRD read ports and NWR write ports, with configurable width and depth.
- Adds an internal scoreboard: one pending bit per register, set at issue and cleared at writeback. Decode/hazard logic can stall on operands whose producer has not written back.
- Write-through bypass: a read in the same cycle as a write to the same register returns the data being written.

Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of 2, ≥2)
- NRD, 2, number of read ports (1..4)
- NWR, 2, number of write ports (1..2)
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never pending

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- rd_addr  in  NRD*AW  read addresses; port i is slice [i*AW +: AW]; AW = clog2(NREGS)
- rd_data  out  NRD*XLEN  read data, combinational
- rd_pend  out  NRD  1 = operand i still awaiting its producer, combinational
- wr_en  in  NWR  write enables
- wr_addr  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- iss_en  in  1  mark iss_addr pending (destination of an issued instruction)
- iss_addr  in  AW  destination register being issued
- flush  in  1  synchronous clear of all pending bits (pipeline flush)
- pend_cnt  out  clog2(NREGS)+1  registered count of currently pending registers

Behaviour:
- Reset (reset_n=0, async): all registers = 0, all pending bits = 0, pend_cnt = 0. Reset asserted mid-operation discards in-flight writes and issues immediately.
- Write: at posedge, every port with wr_en=1 writes regs[wr_addr] <= wr_data. If ZERO_REG=1, writes to address 0 are ignored. When two ports hit the same address, the higher port index wins.
- Read, port i, combinational, in priority order:
  - ZERO_REG=1 and addr=0 → 0.
  - Otherwise, if a write port with wr_en hits the address this cycle, return its data (highest matching index).
  - Otherwise return regs[addr].
- Write latency is 1 cycle to storage; 0 cycles to readers via the bypass.
- Pending set: iss_en=1 sets pend[iss_addr] at posedge. Ignored for address 0 when ZERO_REG=1.
- Pending clear: any wr_en to address a clears pend[a] at posedge.
- Same-cycle iss_en and write to the same address: pend stays 1 (a new producer supersedes the old one). The write data still commits.
- flush=1: all pend <= 0 at posedge, overriding iss_en in the same cycle. Writes still commit.
- rd_pend[i] = pend[rd_addr_i] AND NOT (a same-cycle write hits rd_addr_i). A bypassed value counts as available. Always 0 for address 0 when ZERO_REG=1.
- pend_cnt: registered popcount of pend, updated at the same edge as pend. Never exceeds NREGS-ZERO_REG.
- Out-of-range parameters are rejected at elaboration (NRD, NWR, NREGS power of 2).

Decomposition:
- Package regfile_pkg holds:
  - the AW computation function (clog2)
  - the default XLEN/NREGS constants
  - the slice-index helper for flattened port vectors
- Sub-module regfile_scoreboard holds the pending-bit array, the set/clear/flush priority, pend_cnt, and the rd_pend lookup.
- The top level holds the storage, the write-port priority and the bypass muxes.

Test Plan:
- Reset then read: hold reset_n=0, then release; read addresses 0..31 → rd_data=0, rd_pend=0, pend_cnt=0.
- Dual write, same address: wr0 (x5, 0x11111111) and wr1 (x5, 0x22222222) in the same cycle → next cycle x5 reads 0x22222222. In the write cycle itself, the bypass also returns 0x22222222.
- x0 protection: write x0 = 0xDEADBEEF and issue x0 → rd_data=0, rd_pend=0, pend_cnt unchanged.
- Scoreboard lifecycle:
  - issue x7 → next cycle rd_pend=1, pend_cnt=1.
  - In the cycle wr_en hits x7 with 0xCAFE0001 → rd_pend=0 and rd_data=0xCAFE0001 via bypass.
  - After that edge → pend_cnt=0.
- Issue/write collision: x9 pending, then same-cycle iss_en x9 plus write x9 = 0x55 → after the edge x9=0x55, pend[x9]=1, pend_cnt=1.
- Flush and async reset:
  - Issue x1, x2, x3 (pend_cnt=3), then flush with iss_en x4 in the same cycle → pend_cnt=0, all rd_pend=0.
  - Later, assert reset_n=0 mid-cycle during a write to x10 → x10=0 immediately, before the next clock edge.
